// File: rtl/axi_rd_pkg.sv
// -----------------------------------------------------------------------------
// axi_rd_pkg
// Shared constants and types for the AXI4 burst read master:
//   - RRESP codes, INCR burst encoding, buffered/modifiable ARCACHE value
//   - 4 KB page size that no burst may cross
//   - top-level FSM state enum
//   - clog2 helper usable in localparam expressions
// -----------------------------------------------------------------------------
package axi_rd_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [3:0] CACHE_BUF   = 4'b0011;

  localparam int unsigned PAGE_BYTES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_rd_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_rd_addr_gen
// Read-address generator: holds the running issue address / remaining beat
// count, clamps each burst to the max length and to the 4 KB page, and runs
// the AR handshake.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load                latch load_addr / load_beats (request accepted)
//   issue_en            top FSM is in RUN
//   slot_free           fewer than the maximum bursts are in flight
//   arready             AR channel ready from the slave
//   arvalid/araddr/arlen registered AR outputs, stable until accepted
//   ar_fire             AR handshake strobe for the outstanding counter
// -----------------------------------------------------------------------------
module axi_rd_addr_gen
  import axi_rd_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_BURST_LEN = 16,
  parameter int BEATS_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [BEATS_WIDTH-1:0] load_beats,
  input  logic                   issue_en,
  input  logic                   slot_free,
  input  logic                   arready,
  output logic                   arvalid,
  output logic [ADDR_WIDTH-1:0]  araddr,
  output logic [7:0]             arlen,
  output logic                   ar_fire
);

  localparam int ADDR_LSB = clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0]  issue_addr_q, issue_addr_d;
  logic [BEATS_WIDTH-1:0] issue_left_q, issue_left_d;
  logic                   arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [7:0]             arlen_q, arlen_d;

  logic [31:0] page_room;
  logic [31:0] burst_len;
  logic [31:0] fired_beats;

  // Sub-beat address bits are discarded: every beat is full width.
  logic unused_lsbs;
  assign unused_lsbs = ^load_addr[ADDR_LSB-1:0];

  assign ar_fire = arvalid_q & arready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    issue_addr_d = issue_addr_q;
    issue_left_d = issue_left_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;

    // Beats left before the next 4 KB page boundary.
    page_room = (32'(PAGE_BYTES) - 32'(issue_addr_q[11:0])) >> ADDR_LSB;
    burst_len = 32'(issue_left_q);
    if (burst_len > 32'(MAX_BURST_LEN)) burst_len = 32'(MAX_BURST_LEN);
    if (burst_len > page_room)          burst_len = page_room;

    // The accepted burst length is recovered from the registered ARLEN.
    fired_beats = 32'(arlen_q) + 32'd1;

    if (load) begin
      issue_addr_d = {load_addr[ADDR_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
      issue_left_d = load_beats;
    end else if (ar_fire) begin
      arvalid_d    = 1'b0;
      issue_addr_d = issue_addr_q + ADDR_WIDTH'(fired_beats << ADDR_LSB);
      issue_left_d = issue_left_q - BEATS_WIDTH'(fired_beats);
    end else if (issue_en && (issue_left_q != '0) && slot_free && !arvalid_q) begin
      araddr_d  = issue_addr_q;
      arlen_d   = 8'(burst_len - 32'd1);
      arvalid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_addr_q <= '0;
      issue_left_q <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
    end else begin
      issue_addr_q <= issue_addr_d;
      issue_left_q <= issue_left_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
    end
  end

  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;

endmodule

// File: rtl/axi_burst_read_master.sv
// -----------------------------------------------------------------------------
// axi_burst_read_master
// Read-only AXI4 master. Splits a request of req_beats beats starting at
// req_addr into INCR bursts (max C_MAX_BURST_LEN beats, never crossing 4 KB),
// keeps up to C_MAX_OUTSTANDING bursts in flight, and streams R data straight
// through to a valid/ready consumer.
// Ports:
//   ACLK, ARESETN        clock, async active-low reset (deasserted synchronously)
//   M_AXI_AR* / M_AXI_R* AXI4 read address and read data channels
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_addr, req_beats  start byte address and total beat count (0 allowed)
//   dout_*               returned data, valid/ready, last beat of request
//   busy, done, rd_err   status: not idle, completion pulse, sticky error
// -----------------------------------------------------------------------------
module axi_burst_read_master
  import axi_rd_pkg::*;
#(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 64,
  parameter int C_M_AXI_ARUSER_WIDTH    = 1,
  parameter int C_M_AXI_RUSER_WIDTH     = 1,
  parameter int C_MAX_BURST_LEN         = 16,
  parameter int C_MAX_OUTSTANDING       = 4,
  parameter int C_REQ_BEATS_WIDTH       = 16
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic [7:0]                         M_AXI_ARLEN,
  output logic [2:0]                         M_AXI_ARSIZE,
  output logic [1:0]                         M_AXI_ARBURST,
  output logic [1:0]                         M_AXI_ARLOCK,
  output logic [3:0]                         M_AXI_ARCACHE,
  output logic [2:0]                         M_AXI_ARPROT,
  output logic [3:0]                         M_AXI_ARQOS,
  output logic [C_M_AXI_ARUSER_WIDTH-1:0]    M_AXI_ARUSER,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RLAST,
  input  logic [C_M_AXI_RUSER_WIDTH-1:0]     M_AXI_RUSER,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]      req_addr,
  input  logic [C_REQ_BEATS_WIDTH-1:0]       req_beats,
  output logic [C_M_AXI_DATA_WIDTH-1:0]      dout_data,
  output logic                               dout_valid,
  input  logic                               dout_ready,
  output logic                               dout_last,
  output logic                               busy,
  output logic                               done,
  output logic                               rd_err
);

  localparam int ADDR_LSB = clog2(C_M_AXI_DATA_WIDTH / 8);
  localparam int OUT_W    = clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [C_REQ_BEATS_WIDTH-1:0] BEATS_ONE = C_REQ_BEATS_WIDTH'(1);
  localparam logic [OUT_W-1:0]             OUT_ONE   = OUT_W'(1);
  localparam logic [OUT_W-1:0]             OUT_MAX   = OUT_W'(C_MAX_OUTSTANDING);

  // Reset asserts asynchronously and releases two clocks after ARESETN rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e                       state_q, state_d;
  logic [C_REQ_BEATS_WIDTH-1:0] rx_left_q, rx_left_d;
  logic [OUT_W-1:0]             outstanding_q, outstanding_d;
  logic                         rd_err_q, rd_err_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic run;
  logic accept;
  logic ar_fire;
  logic r_fire;
  logic rlast_fire;

  assign run        = (state_q == ST_RUN);
  assign req_ready  = (state_q == ST_IDLE);
  assign accept     = req_ready & req_valid;
  assign r_fire     = run & M_AXI_RVALID & dout_ready;
  assign rlast_fire = r_fire & M_AXI_RLAST;

  // IDs and user sideband are not used by this master.
  logic unused_sideband;
  assign unused_sideband = ^{M_AXI_RID, M_AXI_RUSER};

  axi_rd_addr_gen #(
    .ADDR_WIDTH    (C_M_AXI_ADDR_WIDTH),
    .DATA_WIDTH    (C_M_AXI_DATA_WIDTH),
    .MAX_BURST_LEN (C_MAX_BURST_LEN),
    .BEATS_WIDTH   (C_REQ_BEATS_WIDTH)
  ) u_addr_gen (
    .clk        (ACLK),
    .rst_n      (rst_n),
    .load       (accept),
    .load_addr  (req_addr),
    .load_beats (req_beats),
    .issue_en   (run),
    .slot_free  (outstanding_q < OUT_MAX),
    .arready    (M_AXI_ARREADY),
    .arvalid    (M_AXI_ARVALID),
    .araddr     (M_AXI_ARADDR),
    .arlen      (M_AXI_ARLEN),
    .ar_fire    (ar_fire)
  );

  always_comb begin
    state_d       = state_q;
    rx_left_d     = rx_left_q;
    outstanding_d = outstanding_q;
    rd_err_d      = rd_err_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rx_left_d     = req_beats;
          outstanding_d = '0;
          rd_err_d      = 1'b0;
          busy_d        = 1'b1;
          if (req_beats == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (r_fire) begin
          rx_left_d = rx_left_q - BEATS_ONE;
          if (M_AXI_RRESP != RESP_OKAY) rd_err_d = 1'b1;
          if (rx_left_q == BEATS_ONE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        // A burst issued and another retired in the same cycle cancel out.
        unique case ({ar_fire, rlast_fire})
          2'b10:   outstanding_d = outstanding_q + OUT_ONE;
          2'b01:   outstanding_d = outstanding_q - OUT_ONE;
          default: outstanding_d = outstanding_q;
        endcase
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rx_left_q     <= '0;
      outstanding_q <= '0;
      rd_err_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_left_q     <= rx_left_d;
      outstanding_q <= outstanding_d;
      rd_err_q      <= rd_err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Zero-latency data path; gated by RUN so nothing leaks out while idle or in reset.
  assign dout_valid   = run & M_AXI_RVALID;
  assign dout_data    = M_AXI_RDATA;
  assign dout_last    = dout_valid & (rx_left_q == BEATS_ONE);
  assign M_AXI_RREADY = run & dout_ready;

  assign busy   = busy_q;
  assign done   = done_q;
  assign rd_err = rd_err_q;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARSIZE  = 3'(ADDR_LSB);
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 2'b00;
  assign M_AXI_ARCACHE = CACHE_BUF;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = '0;

endmodule

// File: doc/axi_burst_read_master.md
# axi_burst_read_master

Parametrised read-only AXI4 master, the successor to the single-burst bitmap read interface. It accepts a multi-beat read request of arbitrary length and splits it into INCR bursts of at most `C_MAX_BURST_LEN` beats that never cross a 4 KB boundary. It keeps up to `C_MAX_OUTSTANDING` bursts in flight and streams returned data to a valid/ready consumer with backpressure, a last marker, and error status. It sits between display/feature-extraction engines and the PS HP port.

## Interface
- `C_M_AXI_THREAD_ID_WIDTH`, 1: ARID/RID width.
- `C_M_AXI_ADDR_WIDTH`, 32: address width.
- `C_M_AXI_DATA_WIDTH`, 64: data width; power of 2, 32..1024.
- `C_M_AXI_ARUSER_WIDTH`, 1: ARUSER width.
- `C_M_AXI_RUSER_WIDTH`, 1: RUSER width.
- `C_MAX_BURST_LEN`, 16: maximum beats per burst; 1..256.
- `C_MAX_OUTSTANDING`, 4: maximum in-flight bursts; ≥1.
- `C_REQ_BEATS_WIDTH`, 16: width of the request beat count.
- `ACLK` in 1: the single clock.
- `ARESETN` in 1: asynchronous, active-low reset.
- `M_AXI_AR*` out: ID, ADDR, LEN[7:0], SIZE[2:0], BURST[1:0], LOCK[1:0], CACHE[3:0], PROT[2:0], QOS[3:0], USER, VALID; `M_AXI_ARREADY` in.
- `M_AXI_R*` in: ID, DATA, RESP[1:0], LAST, USER, VALID; `M_AXI_RREADY` out.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: high only in IDLE.
- `req_addr` in ADDR_WIDTH: start byte address; low log2(bytes/beat) bits are forced to 0.
- `req_beats` in C_REQ_BEATS_WIDTH: total beats; 0 is legal.
- `dout_data` out DATA_WIDTH: returned data.
- `dout_valid` out 1: data valid.
- `dout_ready` in 1: consumer ready.
- `dout_last` out 1: marks the final beat of the request.
- `busy` out 1: high when not IDLE.
- `done` out 1: one-cycle pulse at request completion.
- `rd_err` out 1: sticky; set by any RRESP ≠ OKAY, cleared when the next request is accepted.

## Operation
- Constant AR fields:
  - ARID 0
  - ARSIZE log2(DATA_WIDTH/8)
  - ARBURST INCR (01)
  - ARLOCK 00
  - ARCACHE 0011
  - ARPROT 000
  - ARQOS 0
  - ARUSER 0
- RID and RUSER are ignored.
- FSM has three states: IDLE → RUN → DONE → IDLE.
  - IDLE: on `req_valid`, latch the address and beat count into `issue_addr`/`issue_left`, set `rx_left = req_beats`, clear `rd_err`. Go to RUN, or to DONE if `req_beats == 0`.
  - RUN, AR generator: when `issue_left > 0`, `outstanding < C_MAX_OUTSTANDING`, and ARVALID is low, register ARADDR = `issue_addr` and ARLEN = len − 1, then assert ARVALID.
    - len = min(`issue_left`, `C_MAX_BURST_LEN`, (4096 − `issue_addr[11:0]`)/bytes_per_beat).
    - On ARVALID & ARREADY: drop ARVALID; `issue_addr += len*bytes`; `issue_left -= len`; `outstanding++`.
  - RUN, data path is combinational pass-through: `dout_valid = RVALID`, `RREADY = dout_ready`, `dout_data = RDATA` (RREADY forced 0 outside RUN).
    - Each R handshake decrements `rx_left`.
    - An R handshake with RLAST decrements `outstanding`.
    - `dout_last = RVALID & (rx_left == 1)`.
  - RUN → DONE on the handshake of the final beat (`rx_left == 1`).
  - DONE: `done = 1` for one cycle, then IDLE.
- Simultaneous AR handshake and RLAST handshake leave `outstanding` unchanged.
- Error beats are still forwarded; `rd_err` sets on the handshake cycle of the error beat.

## Timing
- Reset (async assert, sync deassert internally) clears everything:
  - state IDLE
  - ARVALID, RREADY, `dout_valid`, `dout_last`, `done`, `busy`, `rd_err` all 0
  - ARADDR 0, ARLEN 0, `outstanding` 0
  - Reset mid-burst abandons the transfer; interconnect reset is the system's responsibility.
- First ARVALID is asserted 2 cycles after request acceptance (RUN entry + len compute/register).
- ARVALID, ARADDR and ARLEN stay stable until ARREADY.
- Back-to-back bursts: at most one AR every 2 cycles.
- Data latency is 0 cycles; RVALID → `dout_valid` is combinational.
- `done` asserts in the cycle after the final beat handshake. `req_ready` returns the cycle after `done`.

## Structure
- Package `axi_rd_pkg`: RESP codes (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11), BURST_INCR, CACHE_BUF, the FSM state enum, and a clog2 function.
- Sub-module `axi_rd_addr_gen`: issue_addr/issue_left registers, 4 KB/max-length clamp, and the AR handshake; exports the AR-fire strobe to the top.
- The top level holds the FSM, the outstanding and rx counters, the data pass-through, and status.

## Test plan
- 64-bit data, `req_addr` 0x1000, `req_beats` 4, ARREADY=1 → one AR with ARADDR 0x1000, ARLEN 3; 4 beats out, `dout_last` on the 4th, `done` pulse, `rd_err` 0.
- `req_addr` 0x2000, `req_beats` 40 → ARs (0x2000, 15), (0x2080, 15), (0x2100, 7); 40 beats out.
- `req_addr` 0x0FC0, `req_beats` 16 → ARs (0x0FC0, 7), (0x1000, 7); no burst crosses 0x1000.
- `req_beats` 100, ARREADY=1, RVALID withheld → exactly 4 AR handshakes, then ARVALID stays low until the first RLAST, after which the 5th AR issues.
- `dout_ready` toggling 1010… during a 16-beat burst → RREADY mirrors it; all 16 words are delivered in order with no duplicates. SLVERR on beat 5 → `rd_err` = 1 and still 1 after `done`; `req_beats` 0 → no AR, `done` 1 cycle after acceptance.
- ARESETN pulsed low mid-burst → all outputs at reset values the same cycle; next request proceeds normally.
